fifo_write_arbiter: RTL and testbench

Round-robin arbiter sharing the synchronous reset FIFO write port between NUM_REQ requesters, each using a valid/ready handshake. Grants are held for bursts of up to BURST_LEN beats. The arbiter drives the FIFO's write_enb and data_in directly and back-pressures requesters on the FIFO full flag. It sits in front of the FIFO, on the same clock and reset as the FIFO.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_write_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int idWidth(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

  function automatic int cntWidth(input int burstLen);
    return $clog2(burstLen + 1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// last_i+1 with wrap-around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_o
);

  int idx;

  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_i) + k) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready
// requesters with bursts of up to BURST_LEN beats. Define FIFO_ARB_HIPRI_EN
// to give requester 0 strict priority (preempts other owners).
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  localparam int ID_W     = idWidth(NUM_REQ),
  localparam int CNT_W    = cntWidth(BURST_LEN)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     full,
  output logic                     write_enb,
  output logic [WIDTH-1:0]         data_in,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   lastOwner_q, lastOwner_d;
  logic [CNT_W-1:0]  beatCnt_q, beatCnt_d;

  logic [ID_W-1:0]   rrWinner;
  logic              rrAny;
  logic              inGrant;
  logic              ownerValid;
  logic              beat;
  logic              hipriWin;
  logic              preempt;
  logic              keepLast;
  logic [NUM_REQ-1:0] ownerOneHot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) uPick (
    .req_i    (req_valid),
    .last_i   (lastOwner_q),
    .winner_o (rrWinner),
    .any_o    (rrAny)
  );

`ifdef FIFO_ARB_HIPRI_EN
  assign hipriWin = req_valid[0];
  assign preempt  = (owner_q != '0) && req_valid[0];
  assign keepLast = (owner_q == '0);
`else
  assign hipriWin = 1'b0;
  assign preempt  = 1'b0;
  assign keepLast = 1'b0;
`endif

  assign inGrant     = (state_q == ST_GRANT);
  assign ownerValid  = req_valid[owner_q];
  assign ownerOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  // resetn gates the strobes so nothing is written on the edge that resets the FIFO
  assign beat      = resetn && inGrant && ownerValid && !full;
  assign write_enb = beat;
  assign req_ready = (resetn && inGrant && !full) ? ownerOneHot : '0;
  assign data_in   = inGrant ? req_data[owner_q*WIDTH +: WIDTH] : '0;
  assign grant_id  = owner_q;
  assign busy      = inGrant;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    beatCnt_d   = beatCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rrAny) begin
          owner_d   = hipriWin ? '0 : rrWinner;
          beatCnt_d = '0;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (beat) begin
          beatCnt_d = beatCnt_q + CNT_W'(1);
        end
        // A grant ends on valid drop, on its final beat, or on a priority preempt
        if (!ownerValid || preempt ||
            (beat && beatCnt_q == CNT_W'(BURST_LEN - 1))) begin
          state_d   = ST_IDLE;
          beatCnt_d = '0;
          if (!keepLast) begin
            lastOwner_d = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      lastOwner_q <= ID_W'(NUM_REQ - 1);
      beatCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      beatCnt_q   <= beatCnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed table-driven bench for fifo_write_arbiter (WIDTH=8, NUM_REQ=4,
// BURST_LEN=4); extra priority sequence when FIFO_ARB_HIPRI_EN is defined.
module tb_fifo_write_arbiter;

  logic        clock;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        full;
  logic        write_enb;
  logic [7:0]  data_in;
  logic [1:0]  grant_id;
  logic        busy;

  int checks;
  int fails;

  typedef struct {
    logic        rstn;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic        expWe;
    logic [3:0]  expRdy;
    logic        expBusy;
    logic [1:0]  expGid;
    logic [7:0]  expDin;
    logic        strict;
  } vec_t;

  vec_t vecs[$];

  fifo_write_arbiter #(
    .WIDTH     (8),
    .NUM_REQ   (4),
    .BURST_LEN (4)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .write_enb (write_enb),
    .data_in   (data_in),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rstn, input logic [3:0] valid,
                              input logic [31:0] data, input logic fl,
                              input logic we, input logic [3:0] rdy,
                              input logic bsy, input logic [1:0] gid,
                              input logic [7:0] din, input logic strict);
    vec_t v;
    v.rstn = rstn; v.valid = valid; v.data = data; v.full = fl;
    v.expWe = we; v.expRdy = rdy; v.expBusy = bsy; v.expGid = gid;
    v.expDin = din; v.strict = strict;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drive one vector after the falling edge, compare before the next rising edge
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clock);
    resetn    = v.rstn;
    req_valid = v.valid;
    req_data  = v.data;
    full      = v.full;
    #1;
    checkOutput("write_enb", idx, 32'(write_enb), 32'(v.expWe));
    checkOutput("req_ready", idx, 32'(req_ready), 32'(v.expRdy));
    checkOutput("busy", idx, 32'(busy), 32'(v.expBusy));
    if (v.expBusy || v.strict)
      checkOutput("grant_id", idx, 32'(grant_id), 32'(v.expGid));
    if (v.expWe || v.strict)
      checkOutput("data_in", idx, 32'(data_in), 32'(v.expDin));
  endtask

  initial begin
    int writes;
    int fifoCnt;
    int sent;
    logic weSeen;
    logic [1:0] own;
    logic [7:0] bval;

    checks = 0;
    fails  = 0;
    resetn = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h0;
    full      = 1'b0;
    @(posedge clock);

    // reset with everyone requesting, then the first grant goes to requester 0
    vecs.push_back(mk(0, 4'b1111, 32'hA3A2A1A0, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 1));
    vecs.push_back(mk(0, 4'b1111, 32'hA3A2A1A0, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 1));
    vecs.push_back(mk(1, 4'b0001, 32'hA3A2A1A0, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 1));
    vecs.push_back(mk(1, 4'b0000, 32'hA3A2A1A0, 0, 0, 4'b0001, 1, 2'd0, 8'h00, 0));
    // requester 2 sends 0x11,0x22,0x33 then drops valid
    vecs.push_back(mk(1, 4'b0100, 32'h00110000, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0100, 32'h00110000, 0, 1, 4'b0100, 1, 2'd2, 8'h11, 0));
    vecs.push_back(mk(1, 4'b0100, 32'h00220000, 0, 1, 4'b0100, 1, 2'd2, 8'h22, 0));
    vecs.push_back(mk(1, 4'b0100, 32'h00330000, 0, 1, 4'b0100, 1, 2'd2, 8'h33, 0));
    vecs.push_back(mk(1, 4'b0000, 32'h00000000, 0, 0, 4'b0100, 1, 2'd2, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 0));
    // requester 1: two beats, full for 3 cycles, then beats 3 and 4
    vecs.push_back(mk(1, 4'b0010, 32'h0000B100, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000B100, 0, 1, 4'b0010, 1, 2'd1, 8'hB1, 0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000B200, 0, 1, 4'b0010, 1, 2'd1, 8'hB2, 0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000B300, 1, 0, 4'b0000, 1, 2'd1, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000B300, 1, 0, 4'b0000, 1, 2'd1, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000B300, 1, 0, 4'b0000, 1, 2'd1, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000B300, 0, 1, 4'b0010, 1, 2'd1, 8'hB3, 0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000B400, 0, 1, 4'b0010, 1, 2'd1, 8'hB4, 0));
    // burst limit forces a bubble, then full drop together with valid drop
    vecs.push_back(mk(1, 4'b0010, 32'h0000B500, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000B500, 1, 0, 4'b0000, 1, 2'd1, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0000, 32'h0000B500, 0, 0, 4'b0010, 1, 2'd1, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 0));
    // reset in the middle of requester 3's grant
    vecs.push_back(mk(1, 4'b1000, 32'hC3000000, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 0));
    vecs.push_back(mk(0, 4'b1000, 32'hC3000000, 0, 0, 4'b0000, 1, 2'd3, 8'h00, 0));
    vecs.push_back(mk(1, 4'b1000, 32'hC3000000, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 1));
    vecs.push_back(mk(1, 4'b1000, 32'hC3000000, 0, 1, 4'b1000, 1, 2'd3, 8'hC3, 0));
    vecs.push_back(mk(1, 4'b0000, 32'h00000000, 0, 0, 4'b1000, 1, 2'd3, 8'h00, 0));
    vecs.push_back(mk(1, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 0));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // all four requesters valid: grants 0,1,2,3,0 with 4 beats and one bubble each
    writes = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clock);
      resetn    = 1'b1;
      req_valid = 4'hF;
      req_data  = 32'h53525150;
      full      = 1'b0;
      #1;
      own = 2'((cyc / 5) % 4);
      if (write_enb) writes++;
      if (cyc % 5 == 0) begin
        checkOutput("rr_bubble_busy", cyc, 32'(busy), 32'd0);
      end else begin
        checkOutput("rr_grant_id", cyc, 32'(grant_id), 32'(own));
        checkOutput("rr_write_enb", cyc, 32'(write_enb), 32'd1);
        checkOutput("rr_data_in", cyc, 32'(data_in), 32'h50 + 32'(own));
      end
    end
    checkOutput("rr_write_count", 0, 32'(writes), 32'd20);

    @(negedge clock);
    req_valid = 4'h0;
    #1;
    checkOutput("rr_final_idle", 0, 32'(busy), 32'd0);

    // requester 1 pushes up to 20 beats into a 16-deep FIFO that is never read
    fifoCnt = 0;
    sent    = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      req_valid = (sent < 20) ? 4'b0010 : 4'b0000;
      bval      = 8'h60 + 8'(sent);
      req_data  = {16'h0, bval, 8'h0};
      full      = (fifoCnt >= 16);
      #1;
      weSeen = write_enb;
      if (full && (write_enb || req_ready != 4'b0000))
        checkOutput("fill_strobe_while_full", cyc, {27'd0, req_ready, write_enb}, 32'd0);
      if (write_enb)
        checkOutput("fill_data_in", cyc, 32'(data_in), 32'(bval));
      @(posedge clock);
      if (weSeen) begin
        fifoCnt++;
        sent++;
      end
    end
    checkOutput("fill_write_count", 0, 32'(fifoCnt), 32'd16);
    checkOutput("fill_full_flag", 0, 32'(full), 32'd1);

`ifdef FIFO_ARB_HIPRI_EN
    @(negedge clock);
    resetn = 1'b0; full = 1'b0; req_valid = 4'h0;
    @(posedge clock);
    vecs.delete();
    // requester 0 preempts requester 3, then 3 is re-granted
    vecs.push_back(mk(1, 4'b1000, 32'hD3000000, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 1));
    vecs.push_back(mk(1, 4'b1000, 32'hD3000000, 0, 1, 4'b1000, 1, 2'd3, 8'hD3, 0));
    vecs.push_back(mk(1, 4'b1001, 32'hD40000E0, 0, 1, 4'b1000, 1, 2'd3, 8'hD4, 0));
    vecs.push_back(mk(1, 4'b1001, 32'hD40000E0, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 0));
    vecs.push_back(mk(1, 4'b1001, 32'hD40000E0, 0, 1, 4'b0001, 1, 2'd0, 8'hE0, 0));
    vecs.push_back(mk(1, 4'b1000, 32'hD4000000, 0, 0, 4'b0001, 1, 2'd0, 8'h00, 0));
    vecs.push_back(mk(1, 4'b1000, 32'hD5000000, 0, 0, 4'b0000, 0, 2'd0, 8'h00, 0));
    vecs.push_back(mk(1, 4'b1000, 32'hD5000000, 0, 1, 4'b1000, 1, 2'd3, 8'hD5, 0));
    foreach (vecs[i]) applyStimulus(vecs[i], 100 + i);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
